rx_frame_timer: RTL and testbench
=================================

# rx_frame_timer

Parametrised frame-timing engine for the UART receive path. On a start request it generates single-cycle sample strobes at the centre of every bit of a serial frame:

- start bit, then 1..2^SIZE_BITS−1 data bits
- optional parity bit
- one or two stop bits

It sits between the start-bit edge detector (drives `start`) and the receive shift register/error checker (consumes the strobes). It replaces the fixed two-counter timer with mid-bit sampling, parity/stop modes, abort and a busy indication.

## Interface
- PERIOD_BITS, 14: width of `bit_period` and of the internal cycle counter
- SIZE_BITS, 4: width of `data_size` and `bit_index`
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset; one clock; reset is synchronous and active-high
- start  in  1  request a frame; accepted only in IDLE
- abort  in  1  synchronous frame abort; ignored in IDLE
- data_size  in  SIZE_BITS  data bits per frame; latched at start
- bit_period  in  PERIOD_BITS  clocks per bit; latched at start
- parity_en  in  1  frame contains a parity bit; latched at start
- two_stop  in  1  frame has two stop bits; latched at start
- busy  out  1  frame in progress
- start_strobe  out  1  sample point of start bit
- shift_strobe  out  1  sample point of a data bit
- bit_index  out  SIZE_BITS  index of the data bit being strobed (0 = first)
- parity_strobe  out  1  sample point of parity bit
- stop_strobe  out  1  sample point of a stop bit
- packet_done  out  1  one-cycle pulse, frame complete

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE → START when `start`=1. In that cycle, latch all four config inputs. Clamp `bit_period` < 2 to 2 and `data_size` = 0 to 1.
- Config input changes mid-frame have no effect.
- Define half = bit_period >> 1 (floor, ≥1).
- Cycle 0 is the cycle `start` is sampled high in IDLE. Slot s (s=0 is the start bit) is strobed in cycle half + s·bit_period.
- Slot order:
  - start (`start_strobe`)
  - data_size data slots (`shift_strobe`, `bit_index` = 0..data_size−1)
  - parity slot if `parity_en` (`parity_strobe`)
  - 1 or 2 stop slots (`stop_strobe`)
- START → DATA on start strobe; DATA → PARITY or STOP after the last data strobe; PARITY → STOP on its strobe.
- STOP → IDLE in the cycle after the final stop strobe.
- `packet_done` is asserted coincident with the final `stop_strobe`.
- At most one strobe output is high in any cycle.
- `bit_index` is 0 whenever `shift_strobe` is low.
- `busy` is high from cycle 1 through the `packet_done` cycle inclusive.
- `start` is ignored while busy, including in the `packet_done` cycle. A new start is accepted from the next cycle.
- `abort` (non-IDLE):
  - all strobes and `packet_done` are masked in the abort cycle
  - FSM goes to IDLE and counters clear next cycle
  - `busy` is low from the next cycle
- `rst` has priority over `abort` and `start`.
- Arithmetic: the cycle counter is PERIOD_BITS wide and never wraps, since it clears at every strobe. The slot counter is SIZE_BITS wide; its terminal compare is against the latched data_size.

## Timing
- Reset value of every output: 0; state IDLE.
- Strobes and `packet_done` are combinational decodes of registered state/counters (masked by `abort`). They are valid in the strobe cycle and stable before the next edge.
- Frame latency, start to `packet_done`: half + (data_size + parity_en + 1 + two_stop)·bit_period cycles.
- Minimum restart gap: 1 cycle after `packet_done`.

## Structure
- Package `rx_timer_pkg`:
  - state enum `rx_timer_state_t`
  - constants MIN_BIT_PERIOD=2, MIN_DATA_SIZE=1
- Sub-module `sync_flex_counter`, instantiated twice (cycle counter, slot counter):
  - parameter NUM_CNT_BITS
  - ports: clk, rst, clear, count_enable, rollover_val, count_out, rollover_flag
  - synchronous active-high reset
- FSM and output decode live in `rx_frame_timer`.

## Test plan
- Basic frame: bit_period=10, data_size=8, parity off, one stop, start at cycle 0 → start_strobe@5; shift_strobe@15,25,…,85 with bit_index 0..7; stop_strobe+packet_done@95; busy low@96; start@96 accepted.
- Parity and two stops: same frame with parity_en=1, two_stop=1 → parity_strobe@95; stop_strobe@105,115; packet_done@115 only.
- Odd period: bit_period=7, data_size=5 → strobes@3,10,17,24,31,38,45; packet_done@45.
- Clamping: bit_period=1, data_size=0 → half=1; strobes@1,3,5; packet_done@5.
- Abort and restart: abort@40 in the basic frame → no strobes@40 or later; busy low@41; start@41 restarts (start_strobe@46). Also, bit_period changed to 20 at cycle 30 of an unaborted frame → strobes stay @35,45.
- Reset mid-frame: rst@50 → all outputs 0@51; start held high@50 is ignored; start@51 is accepted. Also, start held high continuously → back-to-back frames with a one-cycle idle gap.

Source files
------------

// File: rtl/rx_timer_pkg.sv
// ---------------------------------------------------------------------------
// rx_timer_pkg
// Shared types and constants for the UART receive frame timer.
//   rx_timer_state_t : frame timer FSM states
//   MIN_BIT_PERIOD   : smallest bit period accepted (shorter values clamp up)
//   MIN_DATA_SIZE    : smallest data bit count accepted (zero clamps up)
// ---------------------------------------------------------------------------
package rx_timer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_timer_state_t;

   localparam int MIN_BIT_PERIOD = 2;
   localparam int MIN_DATA_SIZE  = 1;

endpackage

// File: rtl/sync_flex_counter.sv
// ---------------------------------------------------------------------------
// sync_flex_counter
// Up-counter with programmable rollover. It counts 1..rollover_val and then
// wraps back to 1, so after a clear the first enabled cycle reads 1.
//   clk           : system clock
//   rst           : synchronous active-high reset, count returns to 0
//   clear         : synchronous clear to 0, wins over count_enable
//   count_enable  : advance the count this cycle
//   rollover_val  : terminal value
//   count_out     : current count
//   rollover_flag : count_out equals rollover_val (combinational)
// ---------------------------------------------------------------------------
module sync_flex_counter #(
   parameter int NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    count_enable,
   input  logic [NUM_CNT_BITS-1:0] rollover_val,
   output logic [NUM_CNT_BITS-1:0] count_out,
   output logic                    rollover_flag
);

   assign rollover_flag = (count_out == rollover_val);

   // Count register; reaching the terminal value wraps to 1 rather than 0
   // so that a full period spans exactly rollover_val enabled cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_out <= '0;
      end else if (clear) begin
         count_out <= '0;
      end else if (count_enable) begin
         if (rollover_flag) begin
            count_out <= NUM_CNT_BITS'(1);
         end else begin
            count_out <= count_out + NUM_CNT_BITS'(1);
         end
      end
   end

endmodule

// File: rtl/rx_frame_timer.sv
// ---------------------------------------------------------------------------
// rx_frame_timer
// Generates mid-bit sample strobes for one UART receive frame: start bit,
// data bits, optional parity bit and one or two stop bits.
//   clk, rst      : clock and synchronous active-high reset
//   start         : frame request, accepted only when idle
//   abort         : drop the current frame (ignored when idle)
//   data_size     : data bits per frame, latched at start (0 treated as 1)
//   bit_period    : clocks per bit, latched at start (<2 treated as 2)
//   parity_en     : frame carries a parity bit, latched at start
//   two_stop      : frame carries two stop bits, latched at start
//   busy          : frame in progress
//   start_strobe  : start bit sample point
//   shift_strobe  : data bit sample point, bit_index names the bit
//   parity_strobe : parity bit sample point
//   stop_strobe   : stop bit sample point
//   packet_done   : pulse coincident with the final stop strobe
// ---------------------------------------------------------------------------
module rx_frame_timer
   import rx_timer_pkg::*;
#(
   parameter int PERIOD_BITS = 14,
   parameter int SIZE_BITS   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic [SIZE_BITS-1:0]   data_size,
   input  logic [PERIOD_BITS-1:0] bit_period,
   input  logic                   parity_en,
   input  logic                   two_stop,
   output logic                   busy,
   output logic                   start_strobe,
   output logic                   shift_strobe,
   output logic [SIZE_BITS-1:0]   bit_index,
   output logic                   parity_strobe,
   output logic                   stop_strobe,
   output logic                   packet_done
);

   rx_timer_state_t        state;
   logic [PERIOD_BITS-1:0] bit_period_q;
   logic [SIZE_BITS-1:0]   data_size_q;
   logic                   parity_en_q;
   logic                   two_stop_q;

   logic [PERIOD_BITS-1:0] half_period;
   logic [PERIOD_BITS-1:0] cycle_count;
   logic [PERIOD_BITS-1:0] cycle_roll;
   logic                   cycle_flag;
   logic                   cycle_clear;
   logic                   cycle_enable;

   logic [SIZE_BITS-1:0]   slot_count;
   logic [SIZE_BITS-1:0]   slot_roll;
   logic                   slot_flag;
   logic                   slot_clear;
   logic                   slot_enable;

   logic                   start_accept;
   logic                   abort_active;
   logic                   bit_tick;
   logic                   last_data;

   assign half_period  = bit_period_q >> 1;
   assign start_accept = (state == IDLE) && start;
   assign abort_active = abort && (state != IDLE);

   // A bit tick is the cycle counter hitting its terminal value; an abort
   // in the same cycle suppresses every strobe.
   assign bit_tick      = cycle_flag && !abort_active;
   assign start_strobe  = bit_tick && (state == START);
   assign shift_strobe  = bit_tick && (state == DATA);
   assign parity_strobe = bit_tick && (state == PARITY);
   assign stop_strobe   = bit_tick && (state == STOP);
   assign packet_done   = stop_strobe && slot_flag;
   assign last_data     = shift_strobe && slot_flag;
   assign bit_index     = shift_strobe ? slot_count : '0;
   assign busy          = (state != IDLE);

   // The cycle counter starts counting in the accept cycle so that the start
   // bit strobe lands half a period later; afterwards each strobe wraps it
   // to 1 and the next strobe follows a full period later.
   assign cycle_roll   = (state == START) ? half_period : bit_period_q;
   assign cycle_enable = start_accept || (state != IDLE);
   assign cycle_clear  = abort_active || packet_done || ((state == IDLE) && !start);

   // The slot counter indexes data bits while in DATA, then is reused to
   // count stop bits, so it is cleared on the way out of DATA.
   assign slot_roll   = (state == STOP) ? SIZE_BITS'(two_stop_q)
                                        : (data_size_q - SIZE_BITS'(1));
   assign slot_enable = shift_strobe || stop_strobe;
   assign slot_clear  = (state == IDLE) || abort_active || last_data || packet_done;

   sync_flex_counter #(
      .NUM_CNT_BITS (PERIOD_BITS)
   ) cycle_counter (
      .clk           (clk),
      .rst           (rst),
      .clear         (cycle_clear),
      .count_enable  (cycle_enable),
      .rollover_val  (cycle_roll),
      .count_out     (cycle_count),
      .rollover_flag (cycle_flag)
   );

   sync_flex_counter #(
      .NUM_CNT_BITS (SIZE_BITS)
   ) slot_counter (
      .clk           (clk),
      .rst           (rst),
      .clear         (slot_clear),
      .count_enable  (slot_enable),
      .rollover_val  (slot_roll),
      .count_out     (slot_count),
      .rollover_flag (slot_flag)
   );

   // Frame FSM plus configuration capture. Configuration is only sampled in
   // the accept cycle, so later input changes cannot disturb a frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         bit_period_q <= '0;
         data_size_q  <= '0;
         parity_en_q  <= 1'b0;
         two_stop_q   <= 1'b0;
      end else if (abort_active) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state        <= START;
                  bit_period_q <= (bit_period < PERIOD_BITS'(MIN_BIT_PERIOD))
                                  ? PERIOD_BITS'(MIN_BIT_PERIOD) : bit_period;
                  data_size_q  <= (data_size == '0)
                                  ? SIZE_BITS'(MIN_DATA_SIZE) : data_size;
                  parity_en_q  <= parity_en;
                  two_stop_q   <= two_stop;
               end
            end
            START: begin
               if (start_strobe) begin
                  state <= DATA;
               end
            end
            DATA: begin
               if (last_data) begin
                  state <= parity_en_q ? PARITY : STOP;
               end
            end
            PARITY: begin
               if (parity_strobe) begin
                  state <= STOP;
               end
            end
            STOP: begin
               if (packet_done) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rx_frame_timer.sv
// ---------------------------------------------------------------------------
// tb_rx_frame_timer
// Directed bench for rx_frame_timer. Each frame is checked cycle by cycle
// against the slot timing rule (slot s sampled at half + s*period) using
// hand-computed half, period, size and completion cycle per vector.
// ---------------------------------------------------------------------------
module tb_rx_frame_timer;

   localparam int PB = 14;
   localparam int SB = 4;

   logic          clk;
   logic          rst;
   logic          start;
   logic          abort;
   logic [SB-1:0] data_size;
   logic [PB-1:0] bit_period;
   logic          parity_en;
   logic          two_stop;
   logic          busy;
   logic          start_strobe;
   logic          shift_strobe;
   logic [SB-1:0] bit_index;
   logic          parity_strobe;
   logic          stop_strobe;
   logic          packet_done;

   int assert_count;
   int fail_count;

   typedef struct {
      int bp;
      int ds;
      bit par;
      bit two;
      bit idle_abort;
      int half;
      int period;
      int dsz;
      int done;
   } vec_t;

   vec_t vecs[6];

   rx_frame_timer #(
      .PERIOD_BITS (PB),
      .SIZE_BITS   (SB)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .abort         (abort),
      .data_size     (data_size),
      .bit_period    (bit_period),
      .parity_en     (parity_en),
      .two_stop      (two_stop),
      .busy          (busy),
      .start_strobe  (start_strobe),
      .shift_strobe  (shift_strobe),
      .bit_index     (bit_index),
      .parity_strobe (parity_strobe),
      .stop_strobe   (stop_strobe),
      .packet_done   (packet_done)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle worth of inputs.
   task automatic applyStimulus(input logic s, input logic a, input logic r,
                                input logic [PB-1:0] bp, input logic [SB-1:0] ds,
                                input logic p, input logic t);
      start      = s;
      abort      = a;
      rst        = r;
      bit_period = bp;
      data_size  = ds;
      parity_en  = p;
      two_stop   = t;
   endtask

   // Compare the packed output bundle {busy, start, shift, index, parity,
   // stop, done} against the expected bundle.
   task automatic checkOutput(input string name, input logic [9:0] act,
                              input logic [9:0] exp_val);
      assert_count++;
      if (act !== exp_val) begin
         fail_count++;
         $display("[TB] FAIL %s: got %b expected %b (busy,ss,sh,idx4,ps,st,pd)",
                  name, act, exp_val);
      end
   endtask

   // Expected outputs in frame-relative cycle c.
   function automatic logic [9:0] model_out(input vec_t v, input int c);
      logic       e_busy, e_ss, e_sh, e_ps, e_st, e_pd;
      logic [3:0] e_idx;
      int         s;
      e_busy = (c >= 1) && (c <= v.done);
      e_pd   = (c == v.done);
      e_ss   = 1'b0;
      e_sh   = 1'b0;
      e_ps   = 1'b0;
      e_st   = 1'b0;
      e_idx  = 4'd0;
      if (c >= v.half && ((c - v.half) % v.period) == 0) begin
         s = (c - v.half) / v.period;
         if (s == 0) begin
            e_ss = 1'b1;
         end else if (s <= v.dsz) begin
            e_sh  = 1'b1;
            e_idx = 4'(s - 1);
         end else if (v.par && s == v.dsz + 1) begin
            e_ps = 1'b1;
         end else if (s <= v.dsz + int'(v.par) + 1 + int'(v.two)) begin
            e_st = 1'b1;
         end
      end
      return {e_busy, e_ss, e_sh, e_idx, e_ps, e_st, e_pd};
   endfunction

   // Run one frame from an idle cycle. stop_kind 1 aborts and 2 resets in
   // cycle stop_at; hold_start keeps start high throughout. Returns in the
   // cycle after completion, abort or reset with inputs for it applied.
   task automatic run_frame(input vec_t v, input int stop_at, input int stop_kind,
                            input bit hold_start, input string tag);
      int         last;
      logic [9:0] e;
      bit         hit;
      last = (stop_at >= 0) ? stop_at : v.done;
      applyStimulus(1'b1, v.idle_abort, 1'b0, PB'(v.bp), SB'(v.ds), v.par, v.two);
      for (int c = 0; c <= last; c++) begin
         @(negedge clk);
         e = model_out(v, c);
         if (stop_kind == 1 && c == stop_at) begin
            e = {e[9], 9'b0};
         end
         checkOutput($sformatf("%s c%0d", tag, c),
                     {busy, start_strobe, shift_strobe, bit_index,
                      parity_strobe, stop_strobe, packet_done}, e);
         @(posedge clk);
         #1;
         hit = (c + 1 == stop_at);
         applyStimulus(hold_start || (stop_kind == 2 && hit),
                       stop_kind == 1 && hit, stop_kind == 2 && hit,
                       PB'($urandom), SB'($urandom),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
   endtask

   // Main sequence: reset, table vectors, then abort, reset and
   // back-to-back corner cases.
   initial begin
      assert_count = 0;
      fail_count   = 0;

      //            bp  ds  par two ia  half per dsz done
      vecs[0] = '{  10,  8,  0,  0,  0,   5, 10,  8,  95};
      vecs[1] = '{  10,  8,  1,  1,  0,   5, 10,  8, 115};
      vecs[2] = '{   7,  5,  0,  0,  0,   3,  7,  5,  45};
      vecs[3] = '{   1,  0,  0,  0,  0,   1,  2,  1,   5};
      vecs[4] = '{   2,  1,  1,  1,  1,   1,  2,  1,   9};
      vecs[5] = '{   3, 15,  0,  1,  0,   1,  3, 15,  52};

      $display("[TB] Starting rx_frame_timer test");
      applyStimulus(1'b1, 1'b1, 1'b1, PB'(10), SB'(8), 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset", {busy, start_strobe, shift_strobe, bit_index,
                            parity_strobe, stop_strobe, packet_done}, 10'b0);
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 1'b0, 1'b0, PB'(10), SB'(8), 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("idle", {busy, start_strobe, shift_strobe, bit_index,
                           parity_strobe, stop_strobe, packet_done}, 10'b0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 6; i++) begin
         run_frame(vecs[i], -1, 0, 1'b0, $sformatf("vec%0d", i));
      end

      $display("[TB] Abort at a data strobe, then restart");
      run_frame(vecs[0], 45, 1, 1'b0, "abort");
      run_frame(vecs[0], -1, 0, 1'b0, "restart");

      $display("[TB] Reset mid-frame with start held");
      run_frame(vecs[0], 50, 2, 1'b0, "midreset");
      run_frame(vecs[2], -1, 0, 1'b0, "afterreset");

      $display("[TB] Start held high, back-to-back frames");
      run_frame(vecs[3], -1, 0, 1'b1, "hold0");
      run_frame(vecs[3], -1, 0, 1'b1, "hold1");
      run_frame(vecs[2], -1, 0, 1'b0, "hold2");

      @(negedge clk);
      checkOutput("final idle", {busy, start_strobe, shift_strobe, bit_index,
                                 parity_strobe, stop_strobe, packet_done}, 10'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               assert_count, fail_count);
      $finish;
   end

endmodule
